// File: rtl/ls_stream_sel_seq.sv
// Sequenced load/store stream-select table: active/shadow context banks with a run/step/loop FSM.
// Optional LS_STREAM_SEL_CHECK_EN adds a sticky cfg_err_o for out-of-range writes and bad kernel lengths.
module ls_stream_sel_seq #(
  parameter int N_GROUPS = 4,
  parameter int N_BANKS  = 2,
  parameter int N_CTX    = 8,
  parameter int N_L_SRC  = 4,
  parameter int N_S_SRC  = 4,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int CW = $clog2(N_CTX),
  localparam int LW = (N_L_SRC > 1) ? $clog2(N_L_SRC) : 1,
  localparam int SW = (N_S_SRC > 1) ? $clog2(N_S_SRC) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_we_i,
  input  logic [GW-1:0]                cfg_grp_i,
  input  logic [BW-1:0]                cfg_bank_i,
  input  logic [CW-1:0]                cfg_ctx_i,
  input  logic [LW-1:0]                cfg_l_sel_i,
  input  logic [SW-1:0]                cfg_s_sel_i,
  input  logic [CW:0]                  len_i,
  input  logic                         loop_i,
  input  logic                         start_i,
  input  logic                         step_i,
  input  logic                         stop_i,
  input  logic                         swap_req_i,
  output logic                         swap_ack_o,
  output logic [N_GROUPS*N_BANKS*LW-1:0] l_stream_sel_o,
  output logic [N_GROUPS*N_BANKS*SW-1:0] s_stream_sel_o,
  output logic [CW-1:0]                ctx_o,
  output logic                         busy_o,
  output logic                         done_o
`ifdef LS_STREAM_SEL_CHECK_EN
  ,
  output logic                         cfg_err_o
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ctx_q, ctx_d;
  logic [CW:0]   len_q, len_d;
  logic          loop_q, loop_d;
  logic          act_q, act_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          reload_q, reload_d;
  logic          upd;
  logic          do_swap;
  logic          wr_ok;
  logic [CW:0]   len_clamp;
  logic          at_last;

  always_comb begin
    len_clamp = len_i;
    if (len_i == '0)
      len_clamp = (CW+1)'(1);
    else if (32'(len_i) > N_CTX)
      len_clamp = (CW+1)'(N_CTX);
  end

  assign at_last = ({1'b0, ctx_q} == (len_q - (CW+1)'(1)));

  // upd reloads the output registers from {act_d, ctx_d}; reload_q refreshes them one
  // cycle after a swap so a write landing on the swap edge is also picked up.
  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    len_d    = len_q;
    loop_d   = loop_q;
    act_d    = act_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    reload_d = 1'b0;
    upd      = reload_q;
    do_swap  = 1'b0;
    case (state_q)
      S_IDLE: begin
        do_swap = swap_req_i;
        if (start_i) begin
          state_d = S_RUN;
          ctx_d   = '0;
          len_d   = len_clamp;
          loop_d  = loop_i;
          upd     = 1'b1;
        end
      end
      S_RUN: begin
        if (swap_req_i)
          pend_d = 1'b1;
        if (stop_i) begin
          state_d = S_IDLE;
          ctx_d   = '0;
          do_swap = pend_q | swap_req_i;
        end else if (step_i) begin
          if (!at_last) begin
            ctx_d = ctx_q + (CW)'(1);
            upd   = 1'b1;
          end else if (loop_q) begin
            ctx_d = '0;
            upd   = 1'b1;
          end else begin
            state_d = S_IDLE;
            ctx_d   = '0;
            done_d  = 1'b1;
            do_swap = pend_q | swap_req_i;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_swap) begin
      act_d    = ~act_q;
      pend_d   = 1'b0;
      ack_d    = 1'b1;
      reload_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ctx_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      act_q    <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      reload_q <= reload_d;
    end
  end

`ifdef LS_STREAM_SEL_CHECK_EN
  logic err_q;
  logic bad_len;

  assign wr_ok   = (32'(cfg_l_sel_i) < N_L_SRC) && (32'(cfg_s_sel_i) < N_S_SRC);
  assign bad_len = (len_i == '0) || (32'(len_i) > N_CTX);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if ((cfg_we_i && !wr_ok) || (state_q == S_IDLE && start_i && bad_len))
      err_q <= 1'b1;
  end

  assign cfg_err_o = err_q;
`else
  assign wr_ok = 1'b1;
`endif

  // One table per (group, bank): two context banks, written only on the shadow side.
  for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_grp
    for (genvar bi = 0; bi < N_BANKS; bi++) begin : g_bank
      localparam int IDX = gi * N_BANKS + bi;
      logic [LW-1:0] l_mem_q [2][N_CTX];
      logic [SW-1:0] s_mem_q [2][N_CTX];
      logic [LW-1:0] l_out_q;
      logic [SW-1:0] s_out_q;
      logic          hit;

      assign hit = cfg_we_i && wr_ok && (cfg_grp_i == GW'(gi)) && (cfg_bank_i == BW'(bi))
                   && (32'(cfg_ctx_i) < N_CTX);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < N_CTX; k++) begin
            l_mem_q[0][k] <= '0;
            l_mem_q[1][k] <= '0;
            s_mem_q[0][k] <= '0;
            s_mem_q[1][k] <= '0;
          end
          l_out_q <= '0;
          s_out_q <= '0;
        end else begin
          if (hit) begin
            l_mem_q[~act_q][cfg_ctx_i] <= cfg_l_sel_i;
            s_mem_q[~act_q][cfg_ctx_i] <= cfg_s_sel_i;
          end
          if (upd) begin
            l_out_q <= l_mem_q[act_d][ctx_d];
            s_out_q <= s_mem_q[act_d][ctx_d];
          end
        end
      end

      assign l_stream_sel_o[IDX*LW +: LW] = l_out_q;
      assign s_stream_sel_o[IDX*SW +: SW] = s_out_q;
    end
  end

  assign swap_ack_o = ack_q;
  assign ctx_o      = ctx_q;
  assign busy_o     = (state_q == S_RUN);
  assign done_o     = done_q;

endmodule

// File: tb/tb_ls_stream_sel_seq.sv
// Scoreboard bench for ls_stream_sel_seq: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them. Build with LS_STREAM_SEL_CHECK_EN to cover cfg_err_o.
module tb_ls_stream_sel_seq;
  localparam int NG = 4, NB = 2, NC = 8, NL = 5, NS = 4;
  localparam int LW = 3, SW = 2, CW = 3;
`ifdef LS_STREAM_SEL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b0, cfg_we_i = 1'b0, loop_i = 1'b0;
  logic start_i = 1'b0, step_i = 1'b0, stop_i = 1'b0, swap_req_i = 1'b0;
  logic [1:0] cfg_grp_i = '0;
  logic [0:0] cfg_bank_i = '0;
  logic [CW-1:0] cfg_ctx_i = '0;
  logic [LW-1:0] cfg_l_sel_i = '0;
  logic [SW-1:0] cfg_s_sel_i = '0;
  logic [CW:0] len_i = '0;
  logic swap_ack_o, busy_o, done_o;
  logic [NG*NB*LW-1:0] l_stream_sel_o;
  logic [NG*NB*SW-1:0] s_stream_sel_o;
  logic [CW-1:0] ctx_o;
  logic cfg_err;

  ls_stream_sel_seq #(.N_GROUPS(NG), .N_BANKS(NB), .N_CTX(NC), .N_L_SRC(NL), .N_S_SRC(NS)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_grp_i(cfg_grp_i),
    .cfg_bank_i(cfg_bank_i), .cfg_ctx_i(cfg_ctx_i), .cfg_l_sel_i(cfg_l_sel_i),
    .cfg_s_sel_i(cfg_s_sel_i), .len_i(len_i), .loop_i(loop_i), .start_i(start_i),
    .step_i(step_i), .stop_i(stop_i), .swap_req_i(swap_req_i), .swap_ack_o(swap_ack_o),
    .l_stream_sel_o(l_stream_sel_o), .s_stream_sel_o(s_stream_sel_o), .ctx_o(ctx_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef LS_STREAM_SEL_CHECK_EN
    , .cfg_err_o(cfg_err)
`endif
  );
`ifndef LS_STREAM_SEL_CHECK_EN
  assign cfg_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string nm;
    int    tgt;
    int    l, c, b, d, a, e;
    bit    z;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string nm, input string fld, input int got, input int want);
    if (want < 0) return;
    chk_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s.%s cyc=%0d: got %0d, expected %0d", nm, fld, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].tgt <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.tgt < cyc) begin
        chk(mon_e.nm, "late", cyc, mon_e.tgt);
      end else begin
        $display("chk %-12s cyc=%0d l10=%0d ctx=%0d busy=%0d done=%0d ack=%0d err=%0d", mon_e.nm,
                 cyc, l_stream_sel_o[(1*NB+0)*LW +: LW], ctx_o, busy_o, done_o, swap_ack_o, cfg_err);
        chk(mon_e.nm, "l_sel10", int'(l_stream_sel_o[(1*NB+0)*LW +: LW]), mon_e.l);
        chk(mon_e.nm, "ctx", int'(ctx_o), mon_e.c);
        chk(mon_e.nm, "busy", int'(busy_o), mon_e.b);
        chk(mon_e.nm, "done", int'(done_o), mon_e.d);
        chk(mon_e.nm, "ack", int'(swap_ack_o), mon_e.a);
        if (CHK != 0) chk(mon_e.nm, "cfg_err", int'(cfg_err), mon_e.e);
        if (mon_e.z) begin
          chk(mon_e.nm, "l_all", int'(l_stream_sel_o), 0);
          chk(mon_e.nm, "s_all", int'(s_stream_sel_o), 0);
        end
      end
    end
  end

  // Drive one cycle of control inputs and queue what the outputs must show after that edge.
  task automatic drive(input string nm, input logic r, st, stp, sp, sw, lp, input logic [CW:0] ln,
                       input int el, ec, eb, ed, ea, input int ee = -1, input bit ez = 1'b0);
    exp_t e;
    rst_i = r; start_i = st; step_i = stp; stop_i = sp; swap_req_i = sw; loop_i = lp; len_i = ln;
    e.nm = nm; e.tgt = cyc + 1; e.l = el; e.c = ec; e.b = eb; e.d = ed; e.a = ea; e.e = ee; e.z = ez;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rst_i = 0; start_i = 0; step_i = 0; stop_i = 0; swap_req_i = 0; loop_i = 0; len_i = '0;
    cfg_we_i = 0;
  endtask

  task automatic cfg_set(input int g, input int b, input int c, input int l, input int s);
    cfg_we_i = 1; cfg_grp_i = 2'(g); cfg_bank_i = 1'(b); cfg_ctx_i = CW'(c);
    cfg_l_sel_i = LW'(l); cfg_s_sel_i = SW'(s);
  endtask

  int loop_seq[7] = '{1, 2, 0, 1, 2, 0, 1};
  int c11[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int l11[10] = '{1, 2, 3, 0, 0, 0, 4, 0, 1, 2};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    drive("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cfg_set(1, 0, k, k, k);
      drive("wr_shadow", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    drive("swap_idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("swap_reload", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("start_len4", 0, 1, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0);
    for (int k = 1; k < 4; k++) drive("step", 0, 0, 1, 0, 0, 0, 0, k, k, 1, 0, 0);
    drive("step_done", 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0);
    drive("step_idle", 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0);

    drive("start_loop3", 0, 1, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0);
    for (int k = 0; k < 7; k++) drive("loop_step", 0, 0, 1, 0, 0, 0, 0, loop_seq[k], loop_seq[k], 1, 0, 0);
    drive("stop_loop", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

    drive("start_len2", 0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0);
    cfg_set(1, 0, 0, 2, 2);
    drive("wr_swap_run", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    drive("step", 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    drive("done_ack", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    drive("post_swap", 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);

    drive("start_len0", 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, (CHK != 0) ? 1 : -1);
    drive("len0_done", 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);

    cfg_set(1, 0, 7, 4, 3);
    drive("wr_ctx7", 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    drive("start_swap11", 0, 1, 0, 0, 1, 1, 11, 0, 0, 1, 0, 1);
    for (int k = 0; k < 10; k++) drive("len11_step", 0, 0, 1, 0, 0, 0, 0, l11[k], c11[k], 1, 0, 0);
    drive("stop_step", 0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0);

    cfg_set(1, 0, 0, 3, 1);
    drive("wr_on_swap", 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1);
    drive("reload_wr", 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);

    drive("start_len4b", 0, 1, 0, 0, 0, 0, 4, 3, 0, 1, 0, 0);
    drive("rst_midrun", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    cfg_set(1, 0, 0, 5, 0);
    drive("wr_bad_l", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive("swap_bad", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    drive("reload_bad", 0, 0, 0, 0, 0, 0, 0, (CHK != 0) ? 0 : 5, 0, 0, 0, 0, 1);
    drive("err_sticky", 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 1);
    drive("rst_err", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("drain", "queue", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
